// File: rtl/frame_stack_if.sv
// Operand-stack bus: decoder-side op request and registered stack view.
interface frame_stack_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned FRAMES = 4
);
   logic [2:0]        op;
   logic [WIDTH-1:0]  data;
   logic [DEPTH-1:0]  offset;
   logic [WIDTH-1:0]  tos;
   logic [WIDTH-1:0]  peek;
   logic [1:0]        status;
   logic [DEPTH:0]    depth;
   logic [FRAMES:0]   frame_depth;

   modport master (
      output op, data, offset,
      input  tos, peek, status, depth, frame_depth
   );

   modport slave (
      input  op, data, offset,
      output tos, peek, status, depth, frame_depth
   );
endinterface

// File: rtl/frame_stack.sv
// Operand stack with call-frame limits, indexed peek and multi-entry drop.
module frame_stack #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned FRAMES = 4
) (
   input logic           clk,
   input logic           reset,
   frame_stack_if.slave  bus
);
   localparam int unsigned IW   = DEPTH + 1;
   localparam int unsigned FW   = FRAMES + 1;
   localparam int unsigned SCAP = 2 ** DEPTH;
   localparam int unsigned FCAP = 2 ** FRAMES;

   localparam logic [2:0] OP_NONE    = 3'd0;
   localparam logic [2:0] OP_PUSH    = 3'd1;
   localparam logic [2:0] OP_POP     = 3'd2;
   localparam logic [2:0] OP_REPLACE = 3'd3;
   localparam logic [2:0] OP_PEEK    = 3'd4;
   localparam logic [2:0] OP_ENTER   = 3'd5;
   localparam logic [2:0] OP_LEAVE   = 3'd6;
   localparam logic [2:0] OP_DROPN   = 3'd7;

   localparam logic [1:0] ST_NONE      = 2'd0;
   localparam logic [1:0] ST_EMPTY     = 2'd1;
   localparam logic [1:0] ST_UNDERFLOW = 2'd2;
   localparam logic [1:0] ST_OVERFLOW  = 2'd3;

   logic [WIDTH-1:0]  mem    [SCAP];
   logic [IW-1:0]     frames [FCAP];

   logic [IW-1:0]     idx, lim, idx_n, lim_n;
   logic [FW-1:0]     fp, fp_n;
   logic [WIDTH-1:0]  tos_q, tos_n, peek_q, peek_n;
   logic [1:0]        status_q, status_n;

   logic              mem_we;
   logic [DEPTH-1:0]  mem_wa;
   logic [WIDTH-1:0]  mem_wd;
   logic              frm_we;
   logic [FRAMES-1:0] frm_wa;
   logic [IW-1:0]     frm_wd;

   logic              err_udf, err_ovf;
   logic [IW-1:0]     avail, off_w;
   logic [WIDTH-1:0]  top;
   logic [DEPTH-1:0]  new_top_a;

   // Next-state decode: one op per cycle, errors leave all state but status intact.
   always_comb begin
      idx_n     = idx;
      lim_n     = lim;
      fp_n      = fp;
      peek_n    = peek_q;
      tos_n     = tos_q;
      status_n  = status_q;
      err_udf   = 1'b0;
      err_ovf   = 1'b0;
      mem_we    = 1'b0;
      mem_wa    = DEPTH'(idx);
      mem_wd    = bus.data;
      frm_we    = 1'b0;
      frm_wa    = FRAMES'(fp);
      frm_wd    = lim;
      avail     = idx - lim;
      off_w     = IW'(bus.offset);
      top       = mem[DEPTH'(idx - IW'(1))];
      new_top_a = '0;

      case (bus.op)
         OP_PUSH: begin
            if (idx == IW'(SCAP)) begin
               err_ovf = 1'b1;
            end else begin
               mem_we = 1'b1;
               mem_wa = DEPTH'(idx);
               idx_n  = idx + IW'(1);
            end
         end
         OP_POP: begin
            if (avail == '0) err_udf = 1'b1;
            else             idx_n   = idx - IW'(1);
         end
         OP_REPLACE: begin
            if (avail == '0) begin
               err_udf = 1'b1;
            end else begin
               mem_we = 1'b1;
               mem_wa = DEPTH'(idx - IW'(1));
            end
         end
         OP_PEEK: begin
            if (off_w >= avail) err_udf = 1'b1;
            else                peek_n  = mem[DEPTH'(idx - IW'(1) - off_w)];
         end
         OP_ENTER: begin
            if (fp == FW'(FCAP)) begin
               err_ovf = 1'b1;
            end else if (off_w > avail) begin
               err_udf = 1'b1;
            end else begin
               frm_we = 1'b1;
               lim_n  = idx - off_w;
               fp_n   = fp + FW'(1);
            end
         end
         OP_LEAVE: begin
            if (fp == '0) begin
               err_udf = 1'b1;
            end else if (bus.offset[0] && avail == '0) begin
               err_udf = 1'b1;
            end else begin
               // Result is read pre-edge and relocated to the base of the closing frame.
               if (bus.offset[0]) begin
                  mem_we = 1'b1;
                  mem_wa = DEPTH'(lim);
                  mem_wd = top;
                  idx_n  = lim + IW'(1);
               end else begin
                  idx_n  = lim;
               end
               lim_n = frames[FRAMES'(fp - FW'(1))];
               fp_n  = fp - FW'(1);
            end
         end
         OP_DROPN: begin
            if (off_w > avail) err_udf = 1'b1;
            else               idx_n   = idx - off_w;
         end
         default: ;
      endcase

      if (err_ovf) begin
         status_n = ST_OVERFLOW;
         peek_n   = peek_q;
      end else if (err_udf) begin
         status_n = ST_UNDERFLOW;
         peek_n   = peek_q;
      end else begin
         status_n  = (idx_n == lim_n) ? ST_EMPTY : ST_NONE;
         new_top_a = DEPTH'(idx_n - IW'(1));
         if (idx_n == '0)                         tos_n = '0;
         else if (mem_we && mem_wa == new_top_a)  tos_n = mem_wd;
         else                                     tos_n = mem[new_top_a];
      end
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         idx      <= '0;
         lim      <= '0;
         fp       <= '0;
         tos_q    <= '0;
         peek_q   <= '0;
         status_q <= ST_EMPTY;
      end else begin
         idx      <= idx_n;
         lim      <= lim_n;
         fp       <= fp_n;
         tos_q    <= tos_n;
         peek_q   <= peek_n;
         status_q <= status_n;
      end
   end

   // Operand and frame memories; contents survive reset, writes suppressed during it.
   always_ff @(posedge clk) begin
      if (reset && mem_we) mem[mem_wa]    <= mem_wd;
      if (reset && frm_we) frames[frm_wa] <= frm_wd;
   end

   assign bus.tos         = tos_q;
   assign bus.peek        = peek_q;
   assign bus.status      = status_q;
   assign bus.depth       = idx - lim;
   assign bus.frame_depth = fp;

endmodule

// File: tb/tb_frame_stack.sv
// Directed plus randomized check of frame_stack against a queue-based model.
module tb_frame_stack;
   localparam int unsigned WIDTH  = 32;
   localparam int unsigned DEPTH  = 3;
   localparam int unsigned FRAMES = 2;
   localparam int SCAP = 2 ** DEPTH;
   localparam int FCAP = 2 ** FRAMES;

   localparam logic [2:0] NONE = 3'd0, PUSH = 3'd1, POP = 3'd2, REPLACE = 3'd3,
                          PEEK = 3'd4, ENTER = 3'd5, LEAVE = 3'd6, DROPN = 3'd7;
   localparam logic [1:0] S_NONE = 2'd0, S_EMPTY = 2'd1, S_UDF = 2'd2, S_OVF = 2'd3;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   frame_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES(FRAMES)) bus ();
   frame_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES(FRAMES)) dut (
      .clk(clk), .reset(reset), .bus(bus));

   // Reference model: visible stack as a queue, saved limits as a queue.
   logic [31:0] stk[$];
   int          frm[$];
   int          lim = 0;
   logic [31:0] exp_tos = 0, exp_peek = 0;
   logic [1:0]  exp_st = S_EMPTY;

   int n_tests = 0, n_fail = 0, step = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s step %0d: observed %h expected %h", tag, step, obs, exp);
      end
   endtask

   task automatic check_all();
      check("tos", bus.tos, exp_tos);
      check("peek", bus.peek, exp_peek);
      check("status", 32'(bus.status), 32'(exp_st));
      check("depth", 32'(bus.depth), 32'(stk.size() - lim));
      check("frame_depth", 32'(bus.frame_depth), 32'(frm.size()));
   endtask

   task automatic model(input logic [2:0] op, input logic [31:0] d, input int off);
      int idx, avail;
      logic [31:0] r;
      bit udf, ovf;
      idx = stk.size();
      avail = idx - lim;
      udf = 0;
      ovf = 0;
      case (op)
         PUSH:    if (idx == SCAP) ovf = 1; else stk.push_back(d);
         POP:     if (avail == 0) udf = 1; else void'(stk.pop_back());
         REPLACE: if (avail == 0) udf = 1; else stk[idx-1] = d;
         PEEK:    if (off >= avail) udf = 1; else exp_peek = stk[idx-1-off];
         ENTER: begin
            if (frm.size() == FCAP) ovf = 1;
            else if (off > avail) udf = 1;
            else begin
               frm.push_back(lim);
               lim = idx - off;
            end
         end
         LEAVE: begin
            if (frm.size() == 0) udf = 1;
            else if (off[0] && avail == 0) udf = 1;
            else begin
               r = stk[idx-1];
               while (stk.size() > lim) void'(stk.pop_back());
               if (off[0]) stk.push_back(r);
               lim = frm.pop_back();
            end
         end
         DROPN: if (off > avail) udf = 1; else repeat (off) void'(stk.pop_back());
         default: ;
      endcase
      if (ovf) exp_st = S_OVF;
      else if (udf) exp_st = S_UDF;
      else begin
         exp_st  = (stk.size() == lim) ? S_EMPTY : S_NONE;
         exp_tos = (stk.size() == 0) ? 32'h0 : stk[stk.size()-1];
      end
   endtask

   task automatic do_op(input logic [2:0] op, input logic [31:0] d, input int off);
      @(negedge clk);
      bus.op = op;
      bus.data = d;
      bus.offset = DEPTH'(off);
      @(posedge clk);
      #1;
      step++;
      model(op, d, off);
      check_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      bus.op = PUSH;
      bus.data = $urandom;
      bus.offset = DEPTH'($urandom_range(0, SCAP-1));
      @(posedge clk);
      #1;
      step++;
      stk.delete();
      frm.delete();
      lim = 0;
      exp_tos = 0;
      exp_peek = 0;
      exp_st = S_EMPTY;
      check_all();
      reset = 1'b1;
   endtask

   initial begin
      logic [2:0] rop;
      bus.op = NONE;
      bus.data = 0;
      bus.offset = 0;
      do_reset();

      // Basic push/pop and underflow at empty.
      do_op(PUSH, 32'h11, 0);
      do_op(PUSH, 32'h22, 0);
      do_op(PUSH, 32'h33, 0);
      check("push_tos", bus.tos, 32'h33);
      check("push_depth", 32'(bus.depth), 32'd3);
      repeat (3) do_op(POP, 0, 0);
      check("pop_empty", 32'(bus.status), 32'(S_EMPTY));
      do_op(POP, 0, 0);
      check("pop_udf", 32'(bus.status), 32'(S_UDF));

      // Fill to capacity, then overflow keeps tos.
      for (int i = 0; i < SCAP; i++) do_op(PUSH, 32'h100 + i, 0);
      do_op(PUSH, 32'hAA, 0);
      check("push_ovf", 32'(bus.status), 32'(S_OVF));
      check("ovf_tos", bus.tos, 32'h100 + SCAP - 1);
      do_op(NONE, 0, 0);
      do_reset();

      // Frame entry hides caller entries.
      do_op(PUSH, 5, 0); do_op(PUSH, 6, 0); do_op(PUSH, 7, 0);
      do_op(ENTER, 0, 2);
      check("enter_fd", 32'(bus.frame_depth), 32'd1);
      repeat (3) do_op(POP, 0, 0);
      do_reset();

      // Leave with one result relocated to frame base.
      do_op(PUSH, 1, 0); do_op(PUSH, 2, 0);
      do_op(ENTER, 0, 1);
      do_op(PUSH, 9, 0); do_op(PUSH, 8, 0);
      do_op(LEAVE, 0, 1);
      check("leave_tos", bus.tos, 32'd8);
      check("leave_depth", 32'(bus.depth), 32'd2);
      do_op(LEAVE, 0, 1);
      check("leave_udf", 32'(bus.status), 32'(S_UDF));
      do_op(ENTER, 0, 2); do_op(REPLACE, 32'h77, 0); do_op(LEAVE, 0, 0);
      do_reset();

      // Peek and drop.
      do_op(PUSH, 32'hA, 0); do_op(PUSH, 32'hB, 0); do_op(PUSH, 32'hC, 0);
      do_op(PEEK, 0, 2);
      check("peek_val", bus.peek, 32'hA);
      do_op(PEEK, 0, 3);
      check("peek_hold", bus.peek, 32'hA);
      do_op(DROPN, 0, 0);
      do_op(DROPN, 0, 2);
      check("dropn_tos", bus.tos, 32'hA);
      do_reset();

      // Frame-stack capacity, then reset mid-sequence.
      for (int i = 0; i < FCAP; i++) do_op(ENTER, 0, 0);
      do_op(ENTER, 0, 0);
      check("enter_ovf", 32'(bus.status), 32'(S_OVF));
      check("ovf_fd", 32'(bus.frame_depth), 32'(FCAP));
      do_op(PUSH, 3, 0);
      do_reset();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            rop = 3'($urandom_range(0, 9) % 8);
            if ($urandom_range(0, 9) < 2) rop = PUSH;
            do_op(rop, $urandom, int'($urandom_range(0, 3)));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/frame_stack.md
# frame_stack

Parametrised operand stack with hardware call-frame support for the WebAssembly execution core. Adds a frame stack of saved underflow limits, so block/call entry and exit happen in one cycle rather than through an externally driven limit. Also adds indexed peek and multi-entry drop. Sits between the instruction decoder and the ALU as the operand store.

## Interface
- WIDTH, 32, bits per stack entry
- DEPTH, 8, log2 of operand-stack entries (capacity 2^DEPTH)
- FRAMES, 4, log2 of frame-stack entries (capacity 2^FRAMES)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- op  in  3  0 NONE, 1 PUSH, 2 POP, 3 REPLACE, 4 PEEK, 5 ENTER, 6 LEAVE, 7 DROPN
- data  in  WIDTH  value for PUSH/REPLACE
- offset  in  DEPTH  PEEK distance, ENTER parameter count, LEAVE arity (bit 0), DROPN count
- tos  out  WIDTH  registered top of stack
- peek  out  WIDTH  registered PEEK result
- status  out  2  NONE / EMPTY / UNDERFLOW / OVERFLOW (stack.vh encodings)
- depth  out  DEPTH+1  index − limit: entries visible in current frame
- frame_depth  out  FRAMES+1  number of open frames

## Operation
- State: operand memory stack[0:2^DEPTH−1], read asynchronously; index (DEPTH+1 bits, 0..2^DEPTH); limit (DEPTH+1 bits); frame memory of 2^FRAMES saved limits; fp (FRAMES+1 bits).
- Reset (reset==0): index=0, limit=0, fp=0, tos=0, peek=0, status=EMPTY. Memory contents are not cleared. Reset overrides op.
- On error, index, limit, fp, memories, tos and peek are unchanged; only status is updated.
- On success, status=EMPTY if new index==new limit, else NONE.
- After success, tos=stack[new index−1] (the written value where applicable); tos=0 if new index==0.
- NONE: refresh tos and status from current state; no change otherwise.
- PUSH:
  - index==2^DEPTH → OVERFLOW.
  - Else stack[index]=data, index+1.
- POP: index==limit → UNDERFLOW; else index−1.
- REPLACE: index==limit → UNDERFLOW; else stack[index−1]=data.
- PEEK:
  - offset ≥ index−limit → UNDERFLOW.
  - Else peek=stack[index−1−offset]; index unchanged; status from depth.
  - peek holds its value on all other ops.
- ENTER:
  - fp==2^FRAMES → OVERFLOW.
  - offset > index−limit → UNDERFLOW.
  - Else frames[fp]=limit, fp+1, limit=index−offset. Parameters stay on the stack, owned by the new frame.
- LEAVE, with a=offset[0]:
  - fp==0 → UNDERFLOW.
  - a==1 and index==limit → UNDERFLOW.
  - Else r=stack[index−1]. If a==1, stack[limit]=r and index=limit+1; otherwise index=limit. Then limit=frames[fp−1], fp−1.
  - Intermediate entries are discarded.
- DROPN:
  - offset > index−limit → UNDERFLOW.
  - Else index−offset. offset==0 behaves as NONE.
- All index arithmetic is unsigned, DEPTH+1 bits. Comparisons happen before the update, so no wrap-around is reachable.

## Timing
- Every op takes a single cycle and sets no busy flag; op is sampled on each rising edge.
- tos, peek, status, depth and frame_depth reflect an op on the edge that executes it, and are valid in the following cycle.
- Back-to-back ops at full rate. A PUSH followed by POP, or ENTER followed by LEAVE, sees the prior update with no hazard.
- LEAVE with a==1 reads and writes the same memory in one edge: read value is pre-edge contents, write lands at limit.
- Reset asserted mid-sequence takes effect on that edge; the op presented in that cycle is discarded.
- status is sticky until the next op; NONE re-derives it.

## Test plan
- Reset, then PUSH 0x11, 0x22, 0x33 → tos=0x33, depth=3, status NONE. POP ×3 → tos=0, status EMPTY. Fourth POP → UNDERFLOW, index still 0.
- DEPTH=2: PUSH ×4 → depth=4, status NONE. Fifth PUSH 0xAA → OVERFLOW, tos unchanged.
- PUSH 5, 6, 7; ENTER offset=2 → depth=2, frame_depth=1. POP ×2 → EMPTY. Third POP → UNDERFLOW.
- PUSH 1, 2; ENTER offset=1; PUSH 9, 8; LEAVE offset=1 → tos=8, depth=2 (entries 1, 8), frame_depth=0, status NONE. LEAVE again → UNDERFLOW.
- PUSH 0xA, 0xB, 0xC; PEEK offset=2 → peek=0xA, tos=0xC. PEEK offset=3 → UNDERFLOW, peek stays 0xA. DROPN offset=2 → tos=0xA, depth=1.
- FRAMES=1: ENTER ×2 succeed; third ENTER → OVERFLOW, frame_depth=2. Reset low mid-sequence → all outputs at reset values next cycle.
